// File: rtl/adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// adc_spi_sampler : periodic trigger + CNV/SCK/SDO reader for a 16-bit ADC
// Revision 1.0 - initial release
// ============================================================================
module adc_spi_sampler #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] sample_period,
  input  logic        adc_sdo,
  output logic        adc_cnv,
  output logic        adc_sck,
  output logic [15:0] ADC_data,
  output logic        data_valid,
  output logic        overrun
);

  // One timer serves both the conversion wait and the SCK half-periods.
  localparam int TMAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] CONV_LAST = TW'(CONV_CYCLES - 1);
  localparam logic [TW-1:0] DIV_LAST  = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      bit_q, bit_d;
  logic            cnv_q, cnv_d;
  logic            sck_q, sck_d;
  logic [15:0]     shift_q, shift_d;
  logic [15:0]     adc_data_q, adc_data_d;
  logic            data_valid_q, data_valid_d;
  logic            overrun_q, overrun_d;
  logic            trigger;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      bit_q        <= '0;
      cnv_q        <= 1'b0;
      sck_q        <= 1'b0;
      shift_q      <= '0;
      adc_data_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      cnv_q        <= cnv_d;
      sck_q        <= sck_d;
      shift_q      <= shift_d;
      adc_data_q   <= adc_data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    bit_d        = bit_q;
    cnv_d        = cnv_q;
    sck_d        = sck_q;
    shift_d      = shift_q;
    adc_data_d   = adc_data_q;
    data_valid_d = 1'b0;
    overrun_d    = overrun_q;
    trigger      = 1'b0;

    if (!enable) begin
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (sample_period != 16'd0) begin
      if (cnt_q == 16'd0) begin
        trigger = 1'b1;
        cnt_d   = sample_period - 16'd1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end else begin
      cnt_d = '0;
    end

    // Triggers that land on a busy frame are dropped, only flagged.
    if (trigger && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_CONVERT;
          cnv_d   = 1'b1;
          timer_d = '0;
        end
      end
      ST_CONVERT: begin
        if (timer_q == CONV_LAST) begin
          state_d = ST_SHIFT;
          cnv_d   = 1'b0;
          sck_d   = 1'b0;
          timer_d = '0;
          bit_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_SHIFT: begin
        if (timer_q == DIV_LAST) begin
          timer_d = '0;
          if (!sck_q) begin
            // SDO is captured on the same edge that raises SCK.
            sck_d   = 1'b1;
            shift_d = {shift_q[14:0], adc_sdo};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d      = ST_DONE;
              adc_data_d   = shift_q;
              data_valid_d = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign adc_cnv    = cnv_q;
  assign adc_sck    = sck_q;
  assign ADC_data   = adc_data_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// tb_adc_spi_sampler : directed + randomized bench with an event-log ADC model
// Revision 1.0 - initial release
// ============================================================================
module tb_adc_spi_sampler;

  localparam int C = 40;
  localparam int D = 2;
  localparam int F = C + 32 * D + 1;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] sample_period;
  logic        adc_sdo;
  logic        adc_cnv;
  logic        adc_sck;
  logic [15:0] ADC_data;
  logic        data_valid;
  logic        overrun;

  adc_spi_sampler #(.CLK_DIV(D), .CONV_CYCLES(C)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .sample_period (sample_period),
    .adc_sdo       (adc_sdo),
    .adc_cnv       (adc_cnv),
    .adc_sck       (adc_sck),
    .ADC_data      (ADC_data),
    .data_valid    (data_valid),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Event logs filled by the monitor; the stimulus only reads them.
  int          rise_q[$];
  int          len_q[$];
  int          sck_r_q[$];
  int          sck_f_q[$];
  int          val_c_q[$];
  logic [15:0] val_d_q[$];
  int          ovr_rises = 0;
  int          frame_idx = 0;
  logic [15:0] words[32];

  logic        p_cnv = 1'b0;
  logic        p_sck = 1'b0;
  logic        p_ovr = 1'b0;
  int          cnv_len = 0;
  int          bit_idx = -1;
  logic [15:0] cur_word = '0;

  // Monitor and ADC model: word chosen at CNV rise, MSB presented when
  // CNV falls, next bit presented after each SCK rise.
  initial adc_sdo = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (adc_cnv && !p_cnv) begin
      rise_q.push_back(cyc);
      cnv_len  = 1;
      cur_word = words[frame_idx % 32];
      frame_idx++;
      bit_idx  = 15;
    end else if (adc_cnv) begin
      cnv_len++;
    end
    if (!adc_cnv && p_cnv) begin
      len_q.push_back(cnv_len);
      if (bit_idx == 15) begin
        adc_sdo = cur_word[15];
        bit_idx = 14;
      end
    end
    if (adc_sck && !p_sck) begin
      sck_r_q.push_back(cyc);
      if (bit_idx >= 0 && bit_idx < 15) begin
        adc_sdo = cur_word[bit_idx];
        bit_idx--;
      end
    end
    if (!adc_sck && p_sck) sck_f_q.push_back(cyc);
    if (data_valid === 1'b1) begin
      val_c_q.push_back(cyc);
      val_d_q.push_back(ADC_data);
    end
    if (overrun === 1'b1 && !p_ovr) ovr_rises++;
    p_cnv = adc_cnv;
    p_sck = adc_sck;
    p_ovr = overrun;
  end

  int r0, l0, s0, f0s, v0, o0, fi0;

  task automatic mark();
    r0  = rise_q.size();
    l0  = len_q.size();
    s0  = sck_r_q.size();
    f0s = sck_f_q.size();
    v0  = val_c_q.size();
    o0  = ovr_rises;
    fi0 = frame_idx;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame k triggered at T+k*P: CNV from T+1 for C cycles, SCK rises
  // every 2D from T+C+D+1, valid with the ADC's word at T+F.
  task automatic check_frames(input int T, input int P, input int K, input int exp_ovr,
                              input string tag);
    check({tag, "_ncnv"}, rise_q.size() - r0, K);
    check({tag, "_nlen"}, len_q.size() - l0, K);
    check({tag, "_nval"}, val_c_q.size() - v0, K);
    check({tag, "_nsckr"}, sck_r_q.size() - s0, 16 * K);
    check({tag, "_nsckf"}, sck_f_q.size() - f0s, 16 * K);
    check({tag, "_novr"}, ovr_rises - o0, exp_ovr);
    for (int k = 0; k < K; k++) begin
      if (r0 + k < rise_q.size())
        check($sformatf("%s_cnvrise%0d", tag, k), rise_q[r0 + k], T + k * P + 1);
      if (l0 + k < len_q.size())
        check($sformatf("%s_cnvlen%0d", tag, k), len_q[l0 + k], C);
      if (v0 + k < val_c_q.size()) begin
        check($sformatf("%s_valcyc%0d", tag, k), val_c_q[v0 + k], T + k * P + F);
        check($sformatf("%s_valdat%0d", tag, k), val_d_q[v0 + k], words[(fi0 + k) % 32]);
      end
      for (int j = 0; j < 16; j++) begin
        int er;
        er = T + k * P + C + D + 1 + 2 * D * j;
        if (s0 + 16 * k + j < sck_r_q.size())
          check($sformatf("%s_sckr%0d_%0d", tag, k, j), sck_r_q[s0 + 16 * k + j], er);
        if (f0s + 16 * k + j < sck_f_q.size())
          check($sformatf("%s_sckf%0d_%0d", tag, k, j), sck_f_q[f0s + 16 * k + j], er + D);
      end
    end
  endtask

  task automatic run_frames(input int P, input int K, output int T);
    enable = 1'b1;
    T = cyc;
    repeat ((K - 1) * P + 1) @(negedge clk);
    enable = 1'b0;
    repeat (F + 10) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cnv"}, adc_cnv, 0);
    check({tag, "_sck"}, adc_sck, 0);
    check({tag, "_data"}, ADC_data, 0);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int T, T2, p;
    for (int i = 0; i < 32; i++) words[i] = '0;
    reset = 1'b1;
    enable = 1'b0;
    sample_period = '0;
    #2 reset = 1'b0;
    #1 check_outputs_zero("rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal period with a fixed ADC word.
    sample_period = 16'd200;
    mark();
    for (int k = 0; k < 3; k++) words[(fi0 + k) % 32] = 16'hA5C3;
    run_frames(200, 3, T);
    check_frames(T, 200, 3, 0, "t1");
    check("t1_ovr_out", overrun, 0);

    // Minimum overrun-free period, alternating extreme words.
    sample_period = 16'd106;
    mark();
    for (int k = 0; k < 4; k++) words[(fi0 + k) % 32] = (k % 2 == 0) ? 16'h0001 : 16'hFFFF;
    run_frames(106, 4, T);
    check_frames(T, 106, 4, 0, "t2");

    // Random legal period and random words.
    p = 106 + int'($urandom_range(0, 150));
    sample_period = 16'(p);
    mark();
    for (int k = 0; k < 3; k++) words[(fi0 + k) % 32] = 16'($urandom);
    run_frames(p, 3, T);
    check_frames(T, p, 3, 0, "trnd");

    // One cycle too short: second trigger lands on DONE.
    sample_period = 16'd105;
    mark();
    words[fi0 % 32] = 16'($urandom);
    enable = 1'b1;
    T = cyc;
    repeat (105) @(negedge clk);
    check("t3_ovr_pre", overrun, 0);
    @(negedge clk);
    check("t3_ovr_set", overrun, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t3_ovr_clr", overrun, 0);
    repeat (F + 10) @(negedge clk);
    check_frames(T, 105, 1, 1, "t3");

    // Enable dropped mid-SHIFT: frame still completes, nothing follows.
    sample_period = 16'd200;
    mark();
    words[fi0 % 32] = 16'($urandom);
    enable = 1'b1;
    T = cyc;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    check_frames(T, 200, 1, 0, "t4");

    // Reset during SHIFT aborts; a fresh full frame follows release.
    enable = 1'b1;
    T = cyc;
    repeat (70) @(negedge clk);
    mark();
    words[fi0 % 32] = 16'($urandom);
    reset = 1'b0;
    #1 check_outputs_zero("t5_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    T2 = cyc;
    @(negedge clk);
    enable = 1'b0;
    repeat (F + 10) @(negedge clk);
    check_frames(T2, 200, 1, 0, "t5");

    // Zero period: no activity at all.
    sample_period = 16'd0;
    mark();
    enable = 1'b1;
    repeat (1000) @(negedge clk);
    check("t6_ncnv", rise_q.size() - r0, 0);
    check("t6_nval", val_c_q.size() - v0, 0);
    check("t6_novr", ovr_rises - o0, 0);
    check("t6_ovr_out", overrun, 0);
    enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
